serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_ctrl.sv | 175 +++++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder controller.
// One shared full_adder processes the two WIDTH-bit operands LSB first, one
// bit per clock, with the carry held in a register between bits. A
// start/busy/done handshake frames each operation.
// Optional feature macro: SERIAL_ADDER_SUB_EN (subtract when sub=1 at accept).
module serial_adder_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Counter value while the final (MSB) bit is being processed.
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;

  logic             fa_sum_s;
  logic             fa_cout_s;
  logic [WIDTH-1:0] b_load_s;
  logic             carry_load_s;

  // The single shared full adder always works on the current LSBs and carry.
  full_adder u_full_adder (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .cin_i  (carry_q),
    .sum_o  (fa_sum_s),
    .cout_o (fa_cout_s)
  );

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is a + ~b + 1: invert B and force the initial carry.
  always_comb begin
    b_load_s     = b;
    carry_load_s = cin;
    if (sub) begin
      b_load_s     = ~b;
      carry_load_s = 1'b1;
    end else begin
      b_load_s     = b;
      carry_load_s = cin;
    end
  end
`else
  // Add-only build: sub is accepted on the port but has no effect.
  logic sub_unused;
  assign sub_unused = sub;

  // Operands load unmodified; carry-in comes straight from cin.
  always_comb begin
    b_load_s     = b;
    carry_load_s = cin;
  end
`endif

  // Next-state logic: accept in IDLE, one bit per edge in RUN.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b_load_s;
          carry_d = carry_load_s;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end else begin
          busy_d  = 1'b0;
        end
      end
      ST_RUN: begin
        // Result fills from the MSB end so bit 0 lands in place after WIDTH shifts.
        sum_d            = sum_q >> 1'b1;
        sum_d[WIDTH-1]   = fa_sum_s;
        a_d              = a_q >> 1'b1;
        b_d              = b_q >> 1'b1;
        carry_d          = fa_cout_s;
        cnt_d            = cnt_q + CNT_W'(1'b1);
        if (cnt_q == LAST_BIT) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cout_d  = fa_cout_s;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register with synchronous active-low reset that discards any partial op.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// One-bit full adder shared across all bit positions.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  // Pure combinational sum and carry.
  always_comb begin
    sum_o  = a_i ^ b_i ^ cin_i;
    cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: a WIDTH=16 instance for the
// handshake/arithmetic sequence and a WIDTH=1 instance for the truth table.
module tb_serial_adder_ctrl;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=16 instance signals
  logic         rst_n, start, cin, sub;
  logic [W-1:0] a, b;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  // WIDTH=1 instance signals
  logic start1, a1, b1, cin1, sub1;
  logic busy1, done1, sum1, cout1;

  int checks   = 0;
  int failures = 0;
  int lat;
  int done_seen;
  logic [W:0] exp_v;

  serial_adder_ctrl #(.WIDTH(W)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1), .sub(sub1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: {cout, sum} from plain integer arithmetic.
  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic mcin, input logic msub);
    longint unsigned full;
    logic sub_eff;
`ifdef SERIAL_ADDER_SUB_EN
    sub_eff = msub;
`else
    logic msub_unused;
    msub_unused = msub;
    sub_eff = 1'b0;
`endif
    if (sub_eff) begin
      full = longint'(ma) - longint'(mb);
      return {(ma >= mb) ? 1'b1 : 1'b0, full[W-1:0]};
    end
    full = longint'(ma) + longint'(mb) + longint'(mcin);
    return full[W:0];
  endfunction

  // Present one request for one edge, then scramble inputs during the run.
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tcin, input logic tsub);
    a = ta; b = tb_v; cin = tcin; sub = tsub; start = 1'b1;
    step();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    lat = 0;
  endtask

  // Wait (bounded) for done; optionally pulse start with 0x7777 at cycle poke_at.
  task automatic wait_done(input string tag, input int poke_at);
    int busy_cycles;
    busy_cycles = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_cycles++;
      if (lat == poke_at) begin
        start = 1'b1; a = 16'h7777; b = 16'h7777;
      end else begin
        start = 1'b0;
      end
      step();
      lat++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(W));
    check({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(W));
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
  endtask

  // Check result at done, then confirm done drops and the result holds.
  task automatic result_hold(input string tag, input logic [W-1:0] es, input logic ec);
    check({tag, "_sum"}, 64'(sum), 64'(es));
    check({tag, "_cout"}, 64'(cout), 64'(ec));
    step();
    check({tag, "_done_drop"}, 64'(done), 64'd0);
    check({tag, "_sum_hold"}, 64'(sum), 64'(es));
    check({tag, "_cout_hold"}, 64'(cout), 64'(ec));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; sub1 = 1'b0;
    step();
    step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst1_busy", 64'(busy1), 64'd0);
    check("rst1_done", 64'(done1), 64'd0);
    rst_n = 1'b1;
    step();

    // Basic add and accept-edge busy
    launch(16'h0001, 16'h0001, 1'b0, 1'b0);
    check("add1_busy_after_accept", 64'(busy), 64'd1);
    wait_done("add1", -1);
    result_hold("add1", 16'h0002, 1'b0);

    launch(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_done("wrap", -1);
    result_hold("wrap", 16'h0000, 1'b1);

    launch(16'h1234, 16'h4321, 1'b1, 1'b0);
    wait_done("cin", -1);
    result_hold("cin", 16'h5556, 1'b0);

    // Start while busy is ignored; then back-to-back start in the done cycle
    launch(16'h0001, 16'h0001, 1'b0, 1'b0);
    wait_done("ign", 5);
    check("ign_sum", 64'(sum), 64'h0002);
    check("ign_cout", 64'(cout), 64'd0);
    launch(16'h8000, 16'h8000, 1'b0, 1'b0);
    check("b2b_busy_after_accept", 64'(busy), 64'd1);
    wait_done("b2b", -1);
    result_hold("b2b", 16'h0000, 1'b1);

    // Reset in the middle of a run
    launch(16'hABCD, 16'h1111, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_sum", 64'(sum), 64'd0);
    check("midrst_cout", 64'(cout), 64'd0);
    done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (done === 1'b1) done_seen++;
    end
    check("midrst_no_done", 64'(done_seen), 64'd0);
    launch(16'h00FF, 16'h0F0F, 1'b0, 1'b0);
    wait_done("post_rst", -1);
    result_hold("post_rst", 16'h100E, 1'b0);

    // Subtract request (ignored when the feature is compiled out)
    launch(16'h0005, 16'h0007, 1'b0, 1'b1);
    wait_done("sub57", -1);
`ifdef SERIAL_ADDER_SUB_EN
    result_hold("sub57", 16'hFFFE, 1'b0);
`else
    result_hold("sub57", 16'h000C, 1'b0);
`endif
    launch(16'h0007, 16'h0005, 1'b0, 1'b1);
    wait_done("sub75", -1);
`ifdef SERIAL_ADDER_SUB_EN
    result_hold("sub75", 16'h0002, 1'b1);
`else
    result_hold("sub75", 16'h000C, 1'b0);
`endif

    // Randomized operations against the arithmetic model
    for (int n = 0; n < 12; n++) begin
      logic [W-1:0] ra, rb;
      logic rc, rs;
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      if (n == 3) begin ra = 16'hFFFF; rb = 16'hFFFF; end
      exp_v = model(ra, rb, rc, rs);
      launch(ra, rb, rc, rs);
      wait_done($sformatf("rnd%0d", n), -1);
      result_hold($sformatf("rnd%0d", n), exp_v[W-1:0], exp_v[W]);
    end

    // WIDTH=1 truth table: done one cycle after each accept
    for (int i = 0; i < 8; i++) begin
      int tot;
      a1 = i[2]; b1 = i[1]; cin1 = i[0]; start1 = 1'b1;
      tot = i[2] + i[1] + i[0];
      step();
      start1 = 1'b0;
      check($sformatf("w1_%0d_busy", i), 64'(busy1), 64'd1);
      check($sformatf("w1_%0d_early_done", i), 64'(done1), 64'd0);
      step();
      check($sformatf("w1_%0d_done", i), 64'(done1), 64'd1);
      check($sformatf("w1_%0d_sum", i), 64'(sum1), 64'(tot % 2));
      check($sformatf("w1_%0d_cout", i), 64'(cout1), 64'(tot / 2));
      step();
      check($sformatf("w1_%0d_done_drop", i), 64'(done1), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
